uart_tx_core: RTL and testbench

//  Parametrised UART transmitter; successor to the fixed 8N1 test-pattern sender.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_core_if.sv | 13 +
 rtl/uart_tx_fifo.sv | 66 ++++++
 rtl/uart_tx_core.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_core.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk, input int unsigned baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Valid/ready word interface into the UART transmitter.
interface uart_tx_core_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data_i;
  logic                 tx_valid_i;
  logic                 tx_ready_o;

  modport master (output tx_data_i, output tx_valid_i, input tx_ready_o);
  modport slave  (input tx_data_i, input tx_valid_i, output tx_ready_o);

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with circular pointers and a registered level/full/empty.
module uart_tx_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             do_push_c;
  logic             do_pop_c;
  logic [LVL_W-1:0] level_d;

  assign rd_data_c = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    do_push_c = push && !full;
    do_pop_c  = pop && !empty;
    level_d   = level;
    if (do_push_c && !do_pop_c) begin
      level_d = level + LVL_W'(1);
    end else if (do_pop_c && !do_push_c) begin
      level_d = level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      level <= level_d;
      full  <= (level_d == LVL_W'(DEPTH));
      empty <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: input FIFO feeding an LSB-first serialiser (start, data, [parity], stop).
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter  int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter  int unsigned BAUD_RATE   = 115_200,
  parameter  int unsigned DATA_BITS   = 8,
  parameter  int unsigned STOP_BITS   = 1,
  parameter  int unsigned FIFO_DEPTH  = 4,
  parameter  int unsigned PARITY_ODD  = 0,
  localparam int unsigned LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  uart_tx_core_if.slave    tx_if,
  output logic             uart_tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  // Elaboration-time parameter legality checks.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_core: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_core: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_core: PARITY_ODD must be 0 or 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_core: BAUD_RATE too high for CLK_FREQ_HZ");
  end

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 line_c;
  logic                 busy_c;
  logic                 pop_c;
  logic                 bit_end_c;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (tx_if.tx_valid_i),
    .wr_data   (tx_if.tx_data_i),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level_o)
  );

  assign tx_if.tx_ready_o = !fifo_full;
  assign bit_end_c        = (baud_cnt_q == CNT_W'(DIV - 1));
  assign busy_c           = (state_q != IDLE) || !fifo_empty;

  // Next-state, bit timing and shifter control; the line level is registered one cycle later.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_end_c ? '0 : baud_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    pop_c      = 1'b0;
    line_c     = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line_c = 1'b0;
        if (bit_end_c) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        line_c = shreg_q[0];
        if (bit_end_c) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        line_c = parity_q;
        if (bit_end_c) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          if (bit_idx_q == IDX_W'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            // Chain straight into the next frame when a word is waiting.
            if (!fifo_empty) begin
              pop_c   = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (pop_c) begin
      shreg_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
      parity_d = (^fifo_rd_data) ^ 1'(PARITY_ODD);
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      uart_tx_o  <= 1'b1;
      busy_o     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      uart_tx_o  <= line_c;
      busy_o     <= busy_c;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: per-cycle line model, table vectors, corner sequences, random words.
// Define UART_TX_PARITY_EN for both RTL and bench to check the parity frame.
module tb_uart_tx_core;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned DB     = 8;
  localparam int unsigned SB     = 1;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PODD   = 0;
  localparam int unsigned LW     = $clog2(DEPTH + 1);
  localparam int unsigned DIV    = (CLK_HZ + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS  = 1;
`else
  localparam int unsigned PBITS  = 0;
`endif
  localparam int unsigned NBITS  = 1 + DB + PBITS + SB;
  localparam int unsigned FRAME  = NBITS * DIV;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          uart_tx;
  logic          busy;
  logic [LW-1:0] level;

  uart_tx_core_if #(.DATA_BITS(DB)) tx_if ();

  uart_tx_core #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .DATA_BITS   (DB),
    .STOP_BITS   (SB),
    .FIFO_DEPTH  (DEPTH),
    .PARITY_ODD  (PODD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .tx_if        (tx_if),
    .uart_tx_o    (uart_tx),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  always #10 clk = ~clk;

  initial begin
    #(20 * 150_000);
    $display("FAIL watchdog: got no summary by cycle 150000, want finish earlier");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;

  logic [DB-1:0] exp_q [$];
  logic [DB-1:0] dec_log [$];
  logic          par_log [$];
  int            start_log [$];
  int            frames_done = 0;

  bit            mon_busy = 1'b0;
  bit            mon_bad = 1'b0;
  bit            spur_seen = 1'b0;
  int            mon_k = 0;
  int            bad_k = 0;
  logic [DB-1:0] mon_word;
  logic [DB-1:0] mon_dec;
  logic          mon_par;

  typedef struct {
    logic [DB-1:0] data;
    logic          par_even;
    int unsigned   gap;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Expected line level for bit slot j of a frame carrying word w.
  function automatic logic exp_bit(input logic [DB-1:0] w, input int j);
    if (j == 0) return 1'b0;
    if (j <= int'(DB)) return w[j-1];
    if (PBITS != 0 && j == int'(DB) + 1) return (^w) ^ (PODD != 0);
    return 1'b1;
  endfunction

  // Follows the line every cycle against the frame expected for the oldest accepted word.
  task automatic monitor_step();
    int j;
    if (!mon_busy) begin
      if (uart_tx !== 1'b0) begin
        spur_seen = 1'b0;
      end else if (exp_q.size() == 0) begin
        if (!spur_seen) check("spurious_start_line", 32'(uart_tx), 32'd1);
        spur_seen = 1'b1;
      end else begin
        mon_word = exp_q.pop_front();
        mon_busy = 1'b1;
        mon_bad  = 1'b0;
        mon_k    = 0;
        mon_dec  = '0;
        mon_par  = 1'b0;
        start_log.push_back(cyc);
      end
    end
    if (mon_busy) begin
      j = mon_k / int'(DIV);
      if (uart_tx !== exp_bit(mon_word, j) && !mon_bad) begin
        mon_bad = 1'b1;
        bad_k   = mon_k;
      end
      if (mon_k % int'(DIV) == int'(DIV / 2)) begin
        if (j >= 1 && j <= int'(DB)) mon_dec[j-1] = uart_tx;
        if (PBITS != 0 && j == int'(DB) + 1) mon_par = uart_tx;
      end
      if (mon_k == int'(FRAME) - 1) begin
        check("frame_first_bad_offset", mon_bad ? 32'(bad_k) : 32'(FRAME), 32'(FRAME));
        check("frame_decoded_word", 32'(mon_dec), 32'(mon_word));
        dec_log.push_back(mon_dec);
        par_log.push_back(mon_par);
        frames_done++;
        mon_busy = 1'b0;
      end else begin
        mon_k++;
      end
    end
  endtask

  task automatic tick();
    bit acc;
    acc = (tx_if.tx_valid_i === 1'b1) && (tx_if.tx_ready_o === 1'b1) && (rst_i === 1'b0);
    @(posedge clk);
    cyc++;
    if (acc) begin
      exp_q.push_back(tx_if.tx_data_i);
      acc_cnt++;
      last_acc_cyc = cyc;
    end
    @(negedge clk);
    monitor_step();
  endtask

  task automatic clear_logs();
    dec_log.delete();
    par_log.delete();
    start_log.delete();
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    tx_if.tx_valid_i = 1'b0;
    exp_q.delete();
    mon_busy  = 1'b0;
    spur_seen = 1'b0;
    repeat (n) tick();
    rst_i = 1'b0;
    clear_logs();
  endtask

  task automatic push_word(input logic [DB-1:0] w);
    int n0;
    int guard;
    n0 = acc_cnt;
    guard = 0;
    tx_if.tx_data_i  = w;
    tx_if.tx_valid_i = 1'b1;
    while (acc_cnt == n0 && guard < 3 * int'(FRAME)) begin
      tick();
      guard++;
    end
    tx_if.tx_valid_i = 1'b0;
    check("push_accepted", 32'(acc_cnt - n0), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && guard < 6 * int'(FRAME)) begin
      tick();
      guard++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] dec_at(input int i);
    return (i < dec_log.size()) ? 32'(dec_log[i]) : 32'hDEAD_BEEF;
  endfunction

  initial begin
    vec_t          tbl [4];
    logic [DB-1:0] w1, w2;
    logic [DB-1:0] rnd_w [$];
    int            guard, c0, lows, n0;

    tbl[0] = '{data: 8'h00, par_even: 1'b0, gap: 0};
    tbl[1] = '{data: 8'hFF, par_even: 1'b0, gap: 0};
    tbl[2] = '{data: 8'h34, par_even: 1'b1, gap: 37};
    tbl[3] = '{data: 8'h80, par_even: 1'b1, gap: 2 * DIV};

    rst_i = 1'b1;
    tx_if.tx_valid_i = 1'b0;
    tx_if.tx_data_i  = '0;
    do_reset(3);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_ready", 32'(tx_if.tx_ready_o), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_level", 32'(level), 32'd0);

    // Single 0x55: start latency and busy fall time.
    push_word(8'h55);
    c0 = last_acc_cyc;
    check("t1_level_after_push", 32'(level), 32'd1);
    guard = 0;
    while (start_log.size() == 0 && guard < 10) begin tick(); guard++; end
    check("t1_start_seen", 32'(start_log.size()), 32'd1);
    if (start_log.size() > 0) begin
      check("t1_start_latency", 32'(start_log[0] - c0), 32'd2);
      guard = 0;
      while (busy === 1'b1 && guard < int'(FRAME) + 50) begin tick(); guard++; end
      check("t1_busy_fall", 32'(cyc - start_log[0]), 32'(FRAME));
    end
    check("t1_frames", 32'(frames_done), 32'd1);

    // Back-to-back "U","4" with no idle gap.
    clear_logs();
    push_word(8'h55);
    push_word(8'h34);
    wait_idle("t2_drain_busy");
    check("t2_frames", 32'(start_log.size()), 32'd2);
    if (start_log.size() == 2) check("t2_gap", 32'(start_log[1] - start_log[0]), 32'(FRAME));
    check("t2_char_U", dec_at(0), 32'h55);
    check("t2_char_4", dec_at(1), 32'h34);

    // Valid held high: FIFO fills behind the shifter, ready returns after the next pop.
    do_reset(2);
    n0 = acc_cnt;
    tx_if.tx_valid_i = 1'b1;
    tx_if.tx_data_i  = DB'($urandom);
    guard = 0;
    while (tx_if.tx_ready_o === 1'b1 && guard < 20) begin
      tick();
      tx_if.tx_data_i = DB'($urandom);
      guard++;
    end
    check("t3_accepted", 32'(acc_cnt - n0), 32'd5);
    check("t3_level_full", 32'(level), 32'(DEPTH));
    guard = 0;
    while (tx_if.tx_ready_o !== 1'b1 && guard < 2 * int'(FRAME)) begin tick(); guard++; end
    tx_if.tx_valid_i = 1'b0;
    if (start_log.size() > 0) check("t3_ready_rise", 32'(cyc - start_log[0]), 32'(FRAME - 1));
    check("t3_level_after_pop", 32'(level), 32'(DEPTH - 1));
    do_reset(2);

    // Input data churns every cycle and a second word is queued mid-frame.
    w1 = DB'($urandom);
    w2 = DB'($urandom);
    push_word(w1);
    repeat (3 * DIV) begin tx_if.tx_data_i = DB'($urandom); tick(); end
    push_word(w2);
    guard = 0;
    while ((busy !== 1'b0 || mon_busy || exp_q.size() != 0) && guard < 4 * int'(FRAME)) begin
      tx_if.tx_data_i = DB'($urandom);
      tick();
      guard++;
    end
    check("t4_drain_busy", 32'(busy), 32'd0);
    check("t4_word1", dec_at(0), 32'(w1));
    check("t4_word2", dec_at(1), 32'(w2));

    // Reset in the middle of data bit 3 with a second word still queued.
    clear_logs();
    push_word(8'hA5);
    push_word(8'h3C);
    guard = 0;
    while (!(mon_busy && mon_k == int'(4 * DIV + DIV / 2)) && guard < 2 * int'(FRAME)) begin
      tick();
      guard++;
    end
    check("t5_reached_bit3", 32'(mon_k), 32'(4 * DIV + DIV / 2));
    rst_i = 1'b1;
    exp_q.delete();
    mon_busy = 1'b0;
    tick();
    check("t5_line_high", 32'(uart_tx), 32'd1);
    check("t5_level_zero", 32'(level), 32'd0);
    check("t5_busy_zero", 32'(busy), 32'd0);
    rst_i = 1'b0;
    lows = 0;
    repeat (FRAME) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("t5_no_restart", 32'(lows), 32'd0);

    // Table vectors: decoded word and, with parity, the sampled parity bit.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      repeat (tbl[i].gap) tick();
      push_word(tbl[i].data);
    end
    wait_idle("tbl_drain_busy");
    check("tbl_frames", 32'(dec_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tbl%0d_word", i), dec_at(i), 32'(tbl[i].data));
`ifdef UART_TX_PARITY_EN
      if (i < par_log.size())
        check($sformatf("tbl%0d_parity", i), 32'(par_log[i]), 32'(tbl[i].par_even ^ (PODD != 0)));
`endif
    end

    // Random words with random idle gaps.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 2 * DIV)) tick();
      w1 = DB'($urandom);
      rnd_w.push_back(w1);
      push_word(w1);
    end
    wait_idle("rnd_drain_busy");
    check("rnd_frames", 32'(dec_log.size()), 32'(rnd_w.size()));
    for (int i = 0; i < rnd_w.size(); i++) begin
      check($sformatf("rnd%0d_word", i), dec_at(i), 32'(rnd_w[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
